// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD lane unpacker: width encodings, lane counts
// and datapath sizing.
package simd_pkg;

  localparam int DATA_W     = 32;
  localparam int BYTE_LANES = DATA_W / 8;

  localparam logic [1:0] W8  = 2'b00;
  localparam logic [1:0] W16 = 2'b01;
  localparam logic [1:0] W32 = 2'b10;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  // Width code 11 falls into the default branch and behaves as 32-bit.
  function automatic logic [2:0] lane_count(input logic [1:0] width);
    case (width)
      W8:      return 3'd4;
      W16:     return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/simd_lane_extract.sv
// Combinational lane selector: picks one logical lane out of a packed word,
// extends it to 32 bits and reports its saturation and last-lane flags.
module simd_lane_extract
  import simd_pkg::*;
(
  input  logic [DATA_W-1:0]     data_i,
  input  logic [1:0]            width_i,
  input  logic [1:0]            lane_i,
  input  logic                  signed_i,
  input  logic [BYTE_LANES-1:0] sat_i,
  output logic [DATA_W-1:0]     value_o,
  output logic                  sat_o,
  output logic                  last_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = data_i[{lane_i, 3'b000} +: 8];
    half_v  = data_i[{lane_i[0], 4'b0000} +: 16];
    value_o = data_i;
    sat_o   = |sat_i;
    last_o  = ({1'b0, lane_i} == (lane_count(width_i) - 3'd1));
    case (width_i)
      W8: begin
        value_o = {{24{signed_i & byte_v[7]}}, byte_v};
        sat_o   = sat_i[lane_i];
      end
      W16: begin
        value_o = {{16{signed_i & half_v[15]}}, half_v};
        sat_o   = lane_i[0] ? (|sat_i[3:2]) : (|sat_i[1:0]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/simd_lane_unpacker.sv
// Splits one packed SIMD adder result into per-lane extended words on a
// valid/ready stream and tracks sticky per-byte saturation.
module simd_lane_unpacker
  import simd_pkg::*;
#(
  parameter int DATA_W     = simd_pkg::DATA_W,
  parameter int BYTE_LANES = simd_pkg::BYTE_LANES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [1:0]            in_width,
  input  logic                  in_signed,
  input  logic [BYTE_LANES-1:0] in_sat_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_lane,
  output logic                  out_last,
  output logic                  out_sat,
  input  logic                  clr_sticky,
  output logic [BYTE_LANES-1:0] sticky_sat
);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [1:0]            width_q, width_d;
  logic                  signed_q, signed_d;
  logic [BYTE_LANES-1:0] sat_q, sat_d;
  logic [1:0]            lane_q, lane_d;
  logic [BYTE_LANES-1:0] sticky_q, sticky_d;

  logic                  out_valid_q, out_last_q, out_sat_q;
  logic [DATA_W-1:0]     out_data_q;
  logic [1:0]            out_lane_q;

  logic                  accept, advance;
  logic [DATA_W-1:0]     ext_value;
  logic                  ext_sat, ext_last;

  assign in_ready = (state_q == IDLE) || (state_q == EMIT && out_last_q && out_ready);
  assign accept   = in_valid && in_ready;
  assign advance  = out_valid_q && out_ready;

  // A new word always wins over advancing: in_ready only opens in EMIT when
  // the last lane is leaving, so the reload replaces the IDLE transition.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    width_d  = width_q;
    signed_d = signed_q;
    sat_d    = sat_q;
    lane_d   = lane_q;
    sticky_d = clr_sticky ? '0 : sticky_q;
    if (accept) begin
      state_d  = EMIT;
      data_d   = in_data;
      width_d  = in_width;
      signed_d = in_signed;
      sat_d    = in_sat_enable;
      lane_d   = 2'd0;
      sticky_d = sticky_d | in_sat_enable;
    end else if (advance) begin
      if (out_last_q) state_d = IDLE;
      else            lane_d  = lane_q + 2'd1;
    end
  end

  // The extractor looks at next-state values so the lane outputs can be
  // registered and still appear the cycle after accept or advance.
  simd_lane_extract u_extract (
    .data_i   (data_d),
    .width_i  (width_d),
    .lane_i   (lane_d),
    .signed_i (signed_d),
    .sat_i    (sat_d),
    .value_o  (ext_value),
    .sat_o    (ext_sat),
    .last_o   (ext_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      width_q     <= W8;
      signed_q    <= 1'b0;
      sat_q       <= '0;
      lane_q      <= 2'd0;
      sticky_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= 2'd0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      width_q     <= width_d;
      signed_q    <= signed_d;
      sat_q       <= sat_d;
      lane_q      <= lane_d;
      sticky_q    <= sticky_d;
      out_valid_q <= (state_d == EMIT);
      out_data_q  <= (state_d == EMIT) ? ext_value : '0;
      out_lane_q  <= (state_d == EMIT) ? lane_d : 2'd0;
      out_last_q  <= (state_d == EMIT) && ext_last;
      out_sat_q   <= (state_d == EMIT) && ext_sat;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_lane   = out_lane_q;
  assign out_last   = out_last_q;
  assign out_sat    = out_sat_q;
  assign sticky_sat = sticky_q;

endmodule

// File: tb/tb_simd_lane_unpacker.sv
// Directed self-checking bench for simd_lane_unpacker: each task drives one
// scenario and compares outputs against hand-computed values.
module tb_simd_lane_unpacker;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_width;
  logic        in_signed;
  logic [3:0]  in_sat_enable;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        out_sat;
  logic        clr_sticky;
  logic [3:0]  sticky_sat;

  int total;
  int bad;

  simd_lane_unpacker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_width      (in_width),
    .in_signed     (in_signed),
    .in_sat_enable (in_sat_enable),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_lane      (out_lane),
    .out_last      (out_last),
    .out_sat       (out_sat),
    .clr_sticky    (clr_sticky),
    .sticky_sat    (sticky_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of the lane stream: {valid, lane, last, sat, data}.
  function automatic logic [36:0] laneView(input logic v, input logic [1:0] l,
                                           input logic la, input logic s,
                                           input logic [31:0] d);
    return {v, l, la, s, d};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_width = 2'b00; in_signed = 1'b0;
    in_sat_enable = '0; out_ready = 1'b0; clr_sticky = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, out_data, out_lane, out_last, out_sat, sticky_sat} !== 41'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got v=%b d=%h l=%0d la=%b s=%b st=%b want all zero",
               out_valid, out_data, out_lane, out_last, out_sat, sticky_sat);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_8bit_signed();
    logic [31:0] expData [4];
    expData[0] = 32'hFFFF_FFFF; expData[1] = 32'h0000_0001;
    expData[2] = 32'hFFFF_FF80; expData[3] = 32'h0000_007F;
    in_valid = 1'b1; in_data = 32'h7F80_01FF; in_width = 2'b00;
    in_signed = 1'b1; in_sat_enable = 4'b0000; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL s8_pre_accept got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (laneView(out_valid, out_lane, out_last, out_sat, out_data) !==
          laneView(1'b1, 2'(k), (k == 3), 1'b0, expData[k])) begin
        bad++;
        $display("[TB] FAIL s8_lane%0d got v=%b l=%0d la=%b s=%b d=%h want v=1 l=%0d la=%b s=0 d=%h",
                 k, out_valid, out_lane, out_last, out_sat, out_data, k, (k == 3), expData[k]);
      end
      @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL s8_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_16bit_sat();
    in_valid = 1'b1; in_data = 32'h8000_7FFF; in_width = 2'b01;
    in_signed = 1'b0; in_sat_enable = 4'b1100; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_sat_enable = 4'b0000;
    total++;
    if (laneView(out_valid, out_lane, out_last, out_sat, out_data) !==
        laneView(1'b1, 2'd0, 1'b0, 1'b0, 32'h0000_7FFF)) begin
      bad++;
      $display("[TB] FAIL u16_lane0 got l=%0d la=%b s=%b d=%h want l=0 la=0 s=0 d=00007fff",
               out_lane, out_last, out_sat, out_data);
    end
    total++;
    if (sticky_sat !== 4'b1100) begin
      bad++;
      $display("[TB] FAIL u16_sticky got %b want 1100", sticky_sat);
    end
    @(negedge clk);
    total++;
    if (laneView(out_valid, out_lane, out_last, out_sat, out_data) !==
        laneView(1'b1, 2'd1, 1'b1, 1'b1, 32'h0000_8000)) begin
      bad++;
      $display("[TB] FAIL u16_lane1 got l=%0d la=%b s=%b d=%h want l=1 la=1 s=1 d=00008000",
               out_lane, out_last, out_sat, out_data);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || sticky_sat !== 4'b1100) begin
      bad++;
      $display("[TB] FAIL u16_drain got v=%b sticky=%b want 0 1100", out_valid, sticky_sat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'hDEAD_BEEF; words[1] = 32'h0000_0001; words[2] = 32'h0000_0002;
    in_width = 2'b10; in_signed = 1'b1; in_sat_enable = 4'b0000; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = words[k];
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_ready%0d got in_ready=%b want 1", k, in_ready);
      end
      @(negedge clk);
      total++;
      if (laneView(out_valid, out_lane, out_last, out_sat, out_data) !==
          laneView(1'b1, 2'd0, 1'b1, 1'b0, words[k])) begin
        bad++;
        $display("[TB] FAIL b2b_word%0d got v=%b l=%0d la=%b d=%h want v=1 l=0 la=1 d=%h",
                 k, out_valid, out_lane, out_last, out_data, words[k]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_width11();
    in_valid = 1'b1; in_data = 32'h0000_8001; in_width = 2'b11;
    in_signed = 1'b1; in_sat_enable = 4'b1000; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_sat_enable = 4'b0000;
    total++;
    if (laneView(out_valid, out_lane, out_last, out_sat, out_data) !==
        laneView(1'b1, 2'd0, 1'b1, 1'b1, 32'h0000_8001)) begin
      bad++;
      $display("[TB] FAIL w11_word got v=%b l=%0d la=%b s=%b d=%h want v=1 l=0 la=1 s=1 d=00008001",
               out_valid, out_lane, out_last, out_sat, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] expData [4];
    expData[0] = 32'h11; expData[1] = 32'h22; expData[2] = 32'h33; expData[3] = 32'h44;
    in_valid = 1'b1; in_data = 32'h4433_2211; in_width = 2'b00;
    in_signed = 1'b0; in_sat_enable = 4'b0000; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (laneView(out_valid, out_lane, out_last, out_sat, out_data) !==
          laneView(1'b1, 2'd1, 1'b0, 1'b0, 32'h22) || in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold%0d got v=%b l=%0d d=%h rdy=%b want v=1 l=1 d=00000022 rdy=0",
                 c, out_valid, out_lane, out_data, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      total++;
      if (laneView(out_valid, out_lane, out_last, out_sat, out_data) !==
          laneView(1'b1, 2'(k), (k == 3), 1'b0, expData[k])) begin
        bad++;
        $display("[TB] FAIL bp_lane%0d got v=%b l=%0d la=%b d=%h want v=1 l=%0d la=%b d=%h",
                 k, out_valid, out_lane, out_last, out_data, k, (k == 3), expData[k]);
      end
      @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_sticky_collision();
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    total++;
    if (sticky_sat !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL sticky_clear got %b want 0000", sticky_sat);
    end
    in_valid = 1'b1; in_data = 32'h0000_0005; in_width = 2'b10;
    in_signed = 1'b0; in_sat_enable = 4'b0011; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (sticky_sat !== 4'b0011 || out_sat !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sticky_set got sticky=%b out_sat=%b want 0011 1", sticky_sat, out_sat);
    end
    in_data = 32'h0000_0006; in_sat_enable = 4'b0100; clr_sticky = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_sat_enable = 4'b0000; clr_sticky = 1'b0;
    total++;
    if (sticky_sat !== 4'b0100 || out_data !== 32'h0000_0006) begin
      bad++;
      $display("[TB] FAIL sticky_collide got sticky=%b d=%h want 0100 00000006", sticky_sat, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 32'hAABB_CCDD; in_width = 2'b00;
    in_signed = 1'b0; in_sat_enable = 4'b0010; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_sat_enable = 4'b0000;
    @(negedge clk);
    total++;
    if (out_lane !== 2'd1 || out_data !== 32'h0000_00CC) begin
      bad++;
      $display("[TB] FAIL rmid_lane1 got l=%0d d=%h want 1 000000cc", out_lane, out_data);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_data, out_lane, out_last, out_sat, sticky_sat} !== 41'd0 ||
        in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rmid_async got v=%b d=%h l=%0d st=%b rdy=%b want zeros rdy=1",
               out_valid, out_data, out_lane, sticky_sat, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL rmid_idle%0d got v=%b rdy=%b want 0 1", c, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_8bit_signed();
    test_16bit_sat();
    test_back_to_back();
    test_width11();
    test_backpressure();
    test_sticky_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simd_lane_unpacker.md
Name: simd_lane_unpacker

Overview:
Consumer-side companion to the SIMD adder's lane control unit. It accepts one packed 32-bit adder result per handshake, together with its width mode and per-byte saturation flags. It then emits each logical lane as a separately extended 32-bit word on a valid/ready stream, and keeps sticky per-byte saturation status for software. It sits between the adder result register and the writeback/serial output path.

Parameters:
DATA_W, 32, packed result width; only 32 is supported.
BYTE_LANES, 4, number of 8-bit byte slices; fixed to DATA_W/8.

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  packed result available
in_ready  out  1  unpacker can accept a packed result
in_data  in  32  packed adder result
in_width  in  2  00=8-bit (4 lanes), 01=16-bit (2 lanes), 10/11=32-bit (1 lane)
in_signed  in  1  1=sign-extend lanes, 0=zero-extend
in_sat_enable  in  4  per-byte saturation-applied flags from lane control
out_valid  out  1  lane word valid
out_ready  in  1  downstream accepts lane word
out_data  out  32  extended lane value
out_lane  out  2  logical lane index, 0 = least significant
out_last  out  1  final lane of the current packed word
out_sat  out  1  this lane was saturated
clr_sticky  in  1  synchronous clear of sticky_sat
sticky_sat  out  4  per-byte OR of in_sat_enable over all accepted words

Behaviour:
- Reset (rst_n low, asynchronous) values:
  - out_valid=0, out_data=0, out_lane=0, out_last=0, out_sat=0, sticky_sat=0.
  - State returns to IDLE, so in_ready=1 once reset is released.
- Reset mid-operation discards all unemitted lanes.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: out_valid=1.
- Accept condition is in_valid && in_ready. On accept, capture data, width, signed and sat_enable, set lane index=0, and go to EMIT. out_valid rises the next cycle (latency 1).
- in_ready is combinational: (state==IDLE) || (state==EMIT && out_last && out_ready). This gives back-to-back 32-bit mode at 1 word/cycle.
- Lane count: 4 for width 00, 2 for 01, 1 for 10/11. Lanes are emitted in ascending order, starting at lane 0 (bits [7:0] or [15:0]).
- Lane extraction:
  - 8-bit: lane k = data[8k+7:8k].
  - 16-bit: lane k = data[16k+15:16k].
  - 32-bit: full word.
  - Upper bits are filled with the lane MSB if signed, zeros otherwise.
- out_sat per lane:
  - 8-bit: sat_enable[k].
  - 16-bit: sat_enable[2k] | sat_enable[2k+1].
  - 32-bit: OR of all four bits.
- out_last=1 when out_lane == lane count - 1.
- Advance on out_valid && out_ready: lane index increments. After the last lane:
  - if a new word is accepted in the same cycle, reload and stay in EMIT;
  - otherwise go to IDLE.
- Backpressure: while out_valid && !out_ready, out_data, out_lane, out_last and out_sat hold stable.
- sticky_sat:
  - On accept, sticky_sat |= in_sat_enable.
  - clr_sticky clears it on the next edge.
  - If clr_sticky and an accept occur in the same cycle, the result is exactly in_sat_enable (new events survive the clear).
- Width 11 is treated as 32-bit; no error is flagged.

Decomposition:
- Package simd_pkg holds:
  - width encodings W8=2'b00, W16=2'b01, W32=2'b10;
  - function lane_count(width) returning 4/2/1;
  - BYTE_LANES constant.
- One sub-module, simd_lane_extract, is natural: purely combinational, inputs data/width/lane/signed/sat_enable, outputs extended value, sat bit and last flag. The FSM, capture registers and sticky logic stay in the top module.

Test Plan:
- 8-bit signed: in_data=32'h7F80_01FF, width=00, signed=1, out_ready=1 -> four words 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FF80, 32'h0000_007F on lanes 0..3, out_last only on lane 3, first out_valid one cycle after accept.
- 16-bit unsigned with saturation: in_data=32'h8000_7FFF, width=01, signed=0, sat_enable=4'b1100 -> 32'h0000_7FFF (out_sat=0), then 32'h0000_8000 (out_sat=1, out_last=1); sticky_sat=4'b1100.
- 32-bit streaming: three words 32'hDEAD_BEEF, 32'h1, 32'h2 with in_valid and out_ready held high -> one out word per cycle, in_ready never drops, out_last=1 on every word.
- Backpressure: 8-bit word, out_ready low for 3 cycles on lane 1 -> out_data and out_lane stay at lane 1 values, in_ready=0, no lane skipped or duplicated.
- Sticky collision: sticky_sat=4'b0011, then clr_sticky=1 in the same cycle as accepting sat_enable=4'b0100 -> sticky_sat=4'b0100 next cycle.
- Reset mid-word: assert rst_n=0 after lane 1 of a 4-lane word -> all outputs 0 immediately, in_ready=1 after release, no remaining lanes emitted.
